// File: rtl/selector_chunk_sched_if.sv
// selector_chunk_sched_if: start/handshake/selector bundle for selector_chunk_sched.
// slave is the scheduler's view and master is the driver's view.
interface selector_chunk_sched_if #(
    parameter int CHUNK_CNT_W = 8
);
    logic                   start_i;
    logic [CHUNK_CNT_W-1:0] chunk_num_i;
    logic                   ifm_src_valid_i;
    logic                   ifm_src_ready_o;
    logic                   filter_src_valid_i;
    logic                   filter_src_ready_o;
    logic                   ifm_wr_valid_o;
    logic                   ifm_wr_ready_i;
    logic                   filter_wr_valid_o;
    logic                   filter_wr_ready_i;
    logic                   sel_data_valid_i;
    logic [7:0]             sel_ifm_data_i;
    logic [7:0]             sel_filter_data_i;
    logic                   sel_chunk_end_i;
    logic                   busy_o;
    logic [31:0]            result_o;
    logic                   result_valid_o;

    modport slave (
        input  start_i, chunk_num_i, ifm_src_valid_i, filter_src_valid_i,
               ifm_wr_ready_i, filter_wr_ready_i, sel_data_valid_i,
               sel_ifm_data_i, sel_filter_data_i, sel_chunk_end_i,
        output ifm_src_ready_o, filter_src_ready_o, ifm_wr_valid_o,
               filter_wr_valid_o, busy_o, result_o, result_valid_o
    );

    modport master (
        output start_i, chunk_num_i, ifm_src_valid_i, filter_src_valid_i,
               ifm_wr_ready_i, filter_wr_ready_i, sel_data_valid_i,
               sel_ifm_data_i, sel_filter_data_i, sel_chunk_end_i,
        input  ifm_src_ready_o, filter_src_ready_o, ifm_wr_valid_o,
               filter_wr_valid_o, busy_o, result_o, result_valid_o
    );
endinterface

// File: rtl/selector_chunk_sched.sv
// selector_chunk_sched: loads chunk_num chunks into the sparse selector and MACs matched byte pairs into one 32-bit result.
// Define SELECTOR_SIGNED_MAC_EN to treat selector bytes as signed int8 (signed product, sign-extended accumulate).
module selector_chunk_sched #(
    parameter int MEM_SIZE    = 128,
    parameter int BUS_SIZE    = 8,
    parameter int CHUNK_CNT_W = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    selector_chunk_sched_if.slave   bus
);
    localparam int BEATS = MEM_SIZE / BUS_SIZE;
    localparam int BW = $clog2(BEATS + 1);
    localparam logic [BW-1:0] BEATS_C = BW'(BEATS);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [CHUNK_CNT_W-1:0] chunk_num_q, chunk_num_d, chunk_cnt_q, chunk_cnt_d, chunk_nxt;
    logic [BW-1:0]          ifm_cnt_q, ifm_cnt_d, flt_cnt_q, flt_cnt_d;
    logic [15:0]            prod_q, prod_d, mul;
    logic                   prod_vld_q, prod_vld_d;
    logic [31:0]            acc_q, acc_d, result_q, result_d, prod_ext;
    logic                   result_vld_q, result_vld_d;
    logic                   in_mac, ifm_room, flt_room;

    always_comb begin
        in_mac = state_q == COMPUTE || state_q == DRAIN;
        ifm_room = state_q == LOAD && ifm_cnt_q != BEATS_C;
        flt_room = state_q == LOAD && flt_cnt_q != BEATS_C;
        bus.ifm_wr_valid_o = bus.ifm_src_valid_i && ifm_room;
        bus.ifm_src_ready_o = bus.ifm_wr_ready_i && ifm_room;
        bus.filter_wr_valid_o = bus.filter_src_valid_i && flt_room;
        bus.filter_src_ready_o = bus.filter_wr_ready_i && flt_room;
`ifdef SELECTOR_SIGNED_MAC_EN
        mul = {{8{bus.sel_ifm_data_i[7]}}, bus.sel_ifm_data_i} * {{8{bus.sel_filter_data_i[7]}}, bus.sel_filter_data_i};
        prod_ext = {{16{prod_q[15]}}, prod_q};
`else
        mul = {8'd0, bus.sel_ifm_data_i} * {8'd0, bus.sel_filter_data_i};
        prod_ext = {16'd0, prod_q};
`endif
        prod_vld_d = in_mac && bus.sel_data_valid_i;
        prod_d = prod_vld_d ? mul : prod_q;
        chunk_nxt = chunk_cnt_q + 1'b1;
        state_d = state_q;
        chunk_num_d = chunk_num_q;
        chunk_cnt_d = chunk_cnt_q;
        ifm_cnt_d = ifm_cnt_q + BW'(bus.ifm_wr_valid_o && bus.ifm_wr_ready_i);
        flt_cnt_d = flt_cnt_q + BW'(bus.filter_wr_valid_o && bus.filter_wr_ready_i);
        acc_d = prod_vld_q ? acc_q + prod_ext : acc_q;
        result_d = result_q;
        result_vld_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start_i) begin
                chunk_num_d = bus.chunk_num_i == '0 ? CHUNK_CNT_W'(1) : bus.chunk_num_i;
                chunk_cnt_d = '0;
                acc_d = '0;
                state_d = LOAD;
            end
            LOAD: if (ifm_cnt_q == BEATS_C && flt_cnt_q == BEATS_C) begin
                ifm_cnt_d = '0;
                flt_cnt_d = '0;
                state_d = COMPUTE;
            end
            COMPUTE: if (bus.sel_chunk_end_i) begin
                chunk_cnt_d = chunk_nxt;
                state_d = chunk_nxt < chunk_num_q ? LOAD : DRAIN;
            end
            DRAIN: begin
                // acc_d already includes the last product captured in COMPUTE
                result_d = acc_d;
                result_vld_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            chunk_num_q <= '0;
            chunk_cnt_q <= '0;
            ifm_cnt_q <= '0;
            flt_cnt_q <= '0;
            prod_q <= '0;
            prod_vld_q <= 1'b0;
            acc_q <= '0;
            result_q <= '0;
            result_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chunk_num_q <= chunk_num_d;
            chunk_cnt_q <= chunk_cnt_d;
            ifm_cnt_q <= ifm_cnt_d;
            flt_cnt_q <= flt_cnt_d;
            prod_q <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q <= acc_d;
            result_q <= result_d;
            result_vld_q <= result_vld_d;
        end
    end

    assign bus.busy_o = state_q != IDLE;
    assign bus.result_o = result_q;
    assign bus.result_valid_o = result_vld_q;
endmodule

// File: doc/selector_chunk_sched.md
Name: selector_chunk_sched

Overview:
- Sequencer for the sparse input selector datapath.
- Per output element, loads chunk_num chunks into the selector's IFM and filter write ports, one chunk at a time, each chunk MEM_SIZE/BUS_SIZE beats per operand.
- Waits for the selector's chunk_end after each chunk, multiplies and accumulates every matched byte pair, then emits one 32-bit result.
- Sits between the upstream chunk source streams and the selector's write and read ports.

Parameters:
- MEM_SIZE, 128, chunk size in bytes; must equal the selector's MEM_SIZE.
- BUS_SIZE, 8, write-bus width in bytes; BEATS = MEM_SIZE/BUS_SIZE (default 16).
- CHUNK_CNT_W, 8, width of the chunk count per output element.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  start one output element; accepted only in IDLE.
- chunk_num_i  in  CHUNK_CNT_W  number of chunks; sampled on accepted start_i.
- ifm_src_valid_i  in  1  upstream IFM beat valid.
- ifm_src_ready_o  out  1  upstream IFM beat ready.
- filter_src_valid_i  in  1  upstream filter beat valid.
- filter_src_ready_o  out  1  upstream filter beat ready.
- ifm_wr_valid_o  out  1  to selector ifm_wr_valid.
- ifm_wr_ready_i  in  1  from selector ifm_wr_ready.
- filter_wr_valid_o  out  1  to selector filter_wr_valid.
- filter_wr_ready_i  in  1  from selector filter_wr_ready.
- sel_data_valid_i  in  1  selector data_valid.
- sel_ifm_data_i  in  8  selector IFM byte.
- sel_filter_data_i  in  8  selector filter byte.
- sel_chunk_end_i  in  1  selector chunk_end.
- busy_o  out  1  high in any state except IDLE.
- result_o  out  32  accumulated sum.
- result_valid_o  out  1  one-cycle pulse when result_o is updated.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all counters, the product register and the accumulator are 0.
  - Outputs at reset: result_o=0, result_valid_o=0, busy_o=0, all valid/ready outputs 0.
- Sideband sizing: the source sparsemap and data buses connect straight to the selector. This block controls only valid/ready.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE:
  - On start_i, latch chunk_num_i. A value of 0 is treated as 1.
  - Clear chunk_cnt and the accumulator, then go to LOAD.
  - start_i is ignored in any other state.
- LOAD:
  - ifm_wr_valid_o = ifm_src_valid_i && (ifm_beat_cnt < BEATS).
  - ifm_src_ready_o = ifm_wr_ready_i && (ifm_beat_cnt < BEATS).
  - ifm_beat_cnt increments on valid&&ready.
  - Filter side is identical and independent; the two operands may complete in any order.
  - When both counters equal BEATS: clear them, go to COMPUTE.
- COMPUTE:
  - All source ready and write valid outputs are 0.
  - On sel_chunk_end_i: chunk_cnt++. If chunk_cnt+1 < chunk_num go to LOAD, else go to DRAIN.
- MAC pipeline (active in COMPUTE and DRAIN):
  - Stage 1: when sel_data_valid_i, prod_r <= ifm*filter (16-bit unsigned) and prod_vld_r <= 1; otherwise prod_vld_r <= 0.
  - Stage 2: when prod_vld_r, acc += zero-extended prod_r. The accumulator wraps mod 2^32 and does not saturate.
  - sel_data_valid_i in the same cycle as sel_chunk_end_i is captured normally.
- DRAIN:
  - Lasts one cycle, so the final product reaches acc.
  - On the next edge: result_o <= final acc, result_valid_o pulses 1, go to IDLE.
  - result_o holds until the next result.
- Latency: last sel_chunk_end_i at cycle N gives result_valid_o at cycle N+2.
- Back-to-back: start_i may be accepted in the IDLE cycle right after the pulse.
- sel_data_valid_i outside COMPUTE/DRAIN is ignored.
- sel_chunk_end_i outside COMPUTE is ignored.

Optional Feature:
- Macro: SELECTOR_SIGNED_MAC_EN.
- Defined: sel_ifm_data_i and sel_filter_data_i are signed int8. The product is a signed 16-bit value, sign-extended into a two's-complement accumulator (still wraps).
- Undefined: unsigned 8x8 as described under Behaviour.

Test Plan:
- Single chunk: chunk_num=1, 16+16 beats with ready always 1, then 3 data_valid pairs (2*3, 4*5, 1*1) and chunk_end on the last pair -> result_o=27, result_valid_o pulses exactly 2 cycles after chunk_end, busy_o returns 0.
- Multi-chunk: chunk_num=3, each chunk contributes 10 -> three LOAD phases of 16 beats per operand, result_o=30, exactly 48 handshakes per operand.
- Backpressure: ifm_wr_ready_i toggles every cycle, filter source valid delayed 20 cycles -> no beat lost or duplicated, COMPUTE entered only after both counts reach 16.
- Edge cases: chunk_num=0 behaves as 1; start_i while busy is ignored; 0xFF*0xFF accumulated 70000 times -> result wraps to (65025*70000) mod 2^32.
- Reset mid-COMPUTE: assert rst_i asynchronously -> outputs 0 immediately, state IDLE; a new start then gives a correct result.
- With SELECTOR_SIGNED_MAC_EN: pairs (-3)*4 and 2*2 -> result_o=0xFFFFFFF8 (-8).
